// File: rtl/s8sp_pkg.sv
// ============================================================================
// s8sp_pkg : shared widths and loader/run state encoding for the s8sp memory
// Revision : 1.0
// ============================================================================
`default_nettype none

package s8sp_pkg;

  localparam int S8SP_AW = 8;
  localparam int S8SP_DW = 8;

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } s8sp_state_t;

endpackage

`default_nettype wire

// File: rtl/s8sp_ram.sv
// ============================================================================
// s8sp_ram : 2^AW x DW RAM, synchronous write (loader or processor), async read
// Revision : 1.0
// ============================================================================
`default_nettype none

module s8sp_ram import s8sp_pkg::*; #(
  parameter int AW = S8SP_AW,
  parameter int DW = S8SP_DW
) (
  input  logic          clk,
  input  logic          i_sel_ld,
  input  logic          i_we,
  input  logic [AW-1:0] i_ld_addr,
  input  logic [DW-1:0] i_ld_data,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_data,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [AW-1:0] w_waddr;
  logic [DW-1:0] w_wdata;

  assign w_waddr = i_sel_ld ? i_ld_addr : i_cpu_addr;
  assign w_wdata = i_sel_ld ? i_ld_data : i_cpu_data;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  assign o_rdata = r_mem[i_cpu_addr];

endmodule

`default_nettype wire

// File: rtl/s8sp_mem.sv
// ============================================================================
// s8sp_mem : boot loader + program/data memory on the processor system bus
// Revision : 1.0
// ============================================================================
`default_nettype none

module s8sp_mem import s8sp_pkg::*; #(
  parameter int AW = S8SP_AW,
  parameter int DW = S8SP_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] add,
  inout  tri   [DW-1:0] dat,
  input  logic          wrt,
  input  logic          rd,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic          ld_start,
  output logic          cpu_reset,
  output logic [AW:0]   ld_count,
  output logic          bus_err
);

  localparam logic [AW-1:0] c_PTR_ONE = 1;
  localparam logic [AW:0]   c_CNT_ONE = 1;

  s8sp_state_t   r_state;
  s8sp_state_t   w_state_nxt;
  logic [AW-1:0] r_ld_ptr;
  logic [AW:0]   r_ld_count;
  logic          r_bus_err;
  logic          w_ld_accept;
  logic          w_cpu_wr;
  logic          w_collide;
  logic          w_drive;
  logic          w_ram_we;
  logic [DW-1:0] w_rdata;

  assign w_ld_accept = (r_state == ST_LOAD) && ld_valid;
  assign w_collide   = (r_state == ST_RUN) && rd && wrt;
  assign w_cpu_wr    = (r_state == ST_RUN) && wrt && !rd;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The final byte is written either on ld_last or when the pointer wraps.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD: if (w_ld_accept && (ld_last || (r_ld_ptr == '1))) w_state_nxt = ST_RUN;
      ST_RUN:  if (ld_start) w_state_nxt = ST_LOAD;
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  always_comb begin
    ld_ready  = 1'b0;
    cpu_reset = 1'b0;
    w_drive   = 1'b0;
    case (r_state)
      ST_LOAD: ld_ready = 1'b1;
      ST_RUN: begin
        cpu_reset = 1'b1;
        w_drive   = rd && !wrt;
      end
      default: ld_ready = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ld_ptr   <= '0;
      r_ld_count <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      if (w_ld_accept) begin
        r_ld_ptr   <= r_ld_ptr + c_PTR_ONE;
        r_ld_count <= r_ld_count + c_CNT_ONE;
      end else if ((r_state == ST_RUN) && ld_start) begin
        r_ld_ptr   <= '0;
        r_ld_count <= '0;
      end
      if (w_collide) begin
        r_bus_err <= 1'b1;
      end
    end
  end

  // Writes are suppressed on a reset edge so an aborted load stops cleanly.
  assign w_ram_we = reset && (w_ld_accept || w_cpu_wr);

  s8sp_ram #(
    .AW(AW),
    .DW(DW)
  ) u_ram (
    .clk        (clk),
    .i_sel_ld   (r_state == ST_LOAD),
    .i_we       (w_ram_we),
    .i_ld_addr  (r_ld_ptr),
    .i_ld_data  (ld_data),
    .i_cpu_addr (add),
    .i_cpu_data (dat),
    .o_rdata    (w_rdata)
  );

  assign dat      = w_drive ? w_rdata : {DW{1'bz}};
  assign ld_count = r_ld_count;
  assign bus_err  = r_bus_err;

endmodule

`default_nettype wire

// File: tb/tb_s8sp_mem.sv
// ============================================================================
// tb_s8sp_mem : directed self-checking bench for s8sp_mem (undriven dat reads FF)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_s8sp_mem;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] add;
  tri1  [7:0] dat;
  logic       wrt;
  logic       rd;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;
  logic       ld_start;
  logic       cpu_reset;
  logic [8:0] ld_count;
  logic       bus_err;

  logic       r_oe;
  logic [7:0] r_dat;
  int         n_total = 0;
  int         n_bad   = 0;

  always #5 clk = ~clk;

  assign dat = r_oe ? r_dat : 8'hzz;

  s8sp_mem #(.AW(8), .DW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .add       (add),
    .dat       (dat),
    .wrt       (wrt),
    .rd        (rd),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .ld_start  (ld_start),
    .cpu_reset (cpu_reset),
    .ld_count  (ld_count),
    .bus_err   (bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic load_byte(input logic [7:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    cyc();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
    add   = a;
    wrt   = 1'b1;
    r_oe  = 1'b1;
    r_dat = d;
    cyc();
    wrt   = 1'b0;
    r_oe  = 1'b0;
  endtask

  task automatic cpu_rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    add = a;
    rd  = 1'b1;
    #1;
    chk(tag, dat, exp);
    rd  = 1'b0;
  endtask

  initial begin
    reset = 1'b0; add = '0; wrt = 1'b0; rd = 1'b0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; ld_start = 1'b0;
    r_oe = 1'b0; r_dat = '0;
    cyc();
    cyc();
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_cpu_reset", cpu_reset, 0);
    chk("rst_ld_count", ld_count, 0);
    chk("rst_bus_err", bus_err, 0);
    add = 8'h01; rd = 1'b1; #1;
    chk("load_rd_no_drive", dat, 8'hFF);
    rd = 1'b0;
    reset = 1'b1;

    // Three-byte load ending on ld_last
    load_byte(8'hA0, 1'b0);
    load_byte(8'hA1, 1'b0);
    chk("ld3_before_last_cpu_reset", cpu_reset, 0);
    load_byte(8'hA2, 1'b1);
    chk("ld3_count", ld_count, 3);
    chk("ld3_cpu_reset", cpu_reset, 1);
    chk("ld3_ld_ready", ld_ready, 0);
    cpu_rd("ld3_rd1", 8'h01, 8'hA1);
    cpu_rd("ld3_rd0", 8'h00, 8'hA0);
    cpu_rd("ld3_rd2", 8'h02, 8'hA2);

    // Write then read-back next cycle; dat floats when rd is low
    cpu_wr(8'h40, 8'h5A);
    cpu_rd("raw_40", 8'h40, 8'h5A);
    add = 8'h40; #1;
    chk("no_rd_z", dat, 8'hFF);

    // Simultaneous rd/wrt: no drive, no write, sticky error
    cpu_wr(8'h10, 8'h33);
    add = 8'h10; rd = 1'b1; wrt = 1'b1; #1;
    chk("collide_no_drive", dat, 8'hFF);
    cyc();
    rd = 1'b0; wrt = 1'b0;
    chk("collide_bus_err", bus_err, 1);
    cpu_rd("collide_no_write", 8'h10, 8'h33);
    cyc();
    cyc();
    chk("bus_err_sticky", bus_err, 1);

    // ld_valid in RUN is ignored, then reload via ld_start
    load_byte(8'h99, 1'b1);
    chk("run_ldv_count", ld_count, 3);
    chk("run_ldv_state", cpu_reset, 1);
    cpu_rd("run_ldv_mem0", 8'h00, 8'hA0);
    ld_start = 1'b1;
    cyc();
    ld_start = 1'b0;
    chk("ldstart_cpu_reset", cpu_reset, 0);
    chk("ldstart_ld_ready", ld_ready, 1);
    chk("ldstart_count", ld_count, 0);
    load_byte(8'h77, 1'b1);
    chk("reload_count", ld_count, 1);
    cpu_rd("reload_mem0", 8'h00, 8'h77);
    cpu_rd("reload_mem1", 8'h01, 8'hA1);

    // Reset aborts a load partway through
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk("reset_clears_bus_err", bus_err, 0);
    load_byte(8'h11, 1'b0);
    load_byte(8'h12, 1'b0);
    chk("abort_count2", ld_count, 2);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk("abort_count0", ld_count, 0);
    chk("abort_cpu_reset", cpu_reset, 0);
    for (int i = 0; i < 5; i++) begin
      load_byte(8'(8'h21 + i), (i == 4));
      if (i < 4) chk($sformatf("reload5_cpu_reset_%0d", i), cpu_reset, 0);
    end
    chk("reload5_count", ld_count, 5);
    chk("reload5_run", cpu_reset, 1);
    cpu_rd("reload5_mem0", 8'h00, 8'h21);
    cpu_rd("reload5_mem4", 8'h04, 8'h25);

    // Full 256-byte load without ld_last
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if (i == 255) begin
        chk("full_pre_count", ld_count, 255);
        chk("full_pre_cpu_reset", cpu_reset, 0);
      end
      load_byte(8'(i * 3 + 1), 1'b0);
    end
    chk("full_count", ld_count, 256);
    chk("full_cpu_reset", cpu_reset, 1);
    chk("full_ld_ready", ld_ready, 0);
    cpu_rd("full_mem0", 8'h00, 8'h01);
    cpu_rd("full_mem255", 8'hFF, 8'hFE);
    cpu_rd("full_mem128", 8'h80, 8'h81);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
